// File: rtl/clk_mon.sv
// Frequency monitor: counts synchronized MON_IN rising edges over a GATE_LEN-cycle window on BUS_CLK.
// Optional macro CLK_MON_CONT_EN adds the CONT port for back-to-back windows.
module clk_mon #(
  parameter int unsigned GATE_LEN  = 4000,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned MIN_CNT   = 0,
  parameter int unsigned MAX_CNT   = 2**CNT_WIDTH-1
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 MON_IN,
  input  logic                 LOCKED_IN,
  input  logic                 START,
`ifdef CLK_MON_CONT_EN
  input  logic                 CONT,
`endif
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] COUNT,
  output logic                 VALID,
  output logic                 FREQ_OK,
  output logic                 ERR,
  output logic [7:0]           LOCK_LOSS_CNT
);

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  localparam logic [15:0]          GATE_LAST = 16'(GATE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] MIN_C     = CNT_WIDTH'(MIN_CNT);
  localparam logic [CNT_WIDTH-1:0] MAX_C     = CNT_WIDTH'(MAX_CNT);

  state_t               state, state_nxt;
  logic [2:0]           mon_sync, lock_sync;
  logic                 mon_rise, lock_fall;
  logic [15:0]          gate_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic [CNT_WIDTH:0]   lo_diff, hi_diff;
  logic                 in_range, gate_start, start_ok, cont_go;

  // Bits [1:0] are the synchronizer, bit [2] is the edge-detect history flop.
  assign mon_rise  = mon_sync[1] & ~mon_sync[2];
  assign lock_fall = ~lock_sync[1] & lock_sync[2];

`ifdef CLK_MON_CONT_EN
  assign cont_go = CONT;
`else
  assign cont_go = 1'b0;
`endif

  // Range test via borrow bits keeps the bounds check free of constant comparisons.
  assign lo_diff  = {1'b0, edge_cnt} - {1'b0, MIN_C};
  assign hi_diff  = {1'b0, MAX_C} - {1'b0, edge_cnt};
  assign in_range = ~lo_diff[CNT_WIDTH] & ~hi_diff[CNT_WIDTH];

  assign start_ok = (state == IDLE) && START;
  assign BUSY     = (state == GATE);

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt  = state;
    gate_start = 1'b0;
    case (state)
      IDLE: if (START) begin
        state_nxt  = GATE;
        gate_start = 1'b1;
      end
      GATE: begin
        if (lock_fall)      state_nxt = IDLE;
        else if (gate_cnt == GATE_LAST) state_nxt = DONE;
      end
      DONE: begin
        if (cont_go) begin
          state_nxt  = GATE;
          gate_start = 1'b1;
        end else begin
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state         <= IDLE;
      mon_sync      <= '0;
      lock_sync     <= '0;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      COUNT         <= '0;
      VALID         <= 1'b0;
      FREQ_OK       <= 1'b0;
      ERR           <= 1'b0;
      LOCK_LOSS_CNT <= '0;
    end else begin
      state     <= state_nxt;
      mon_sync  <= {mon_sync[1:0], MON_IN};
      lock_sync <= {lock_sync[1:0], LOCKED_IN};

      if (gate_start) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else if (state == GATE) begin
        gate_cnt <= gate_cnt + 16'd1;
        if (mon_rise && (edge_cnt != '1)) edge_cnt <= edge_cnt + CNT_WIDTH'(1);
      end

      // Results latch only on a completed window; an aborted window never reaches DONE.
      VALID <= (state == DONE);
      if (state == DONE) begin
        COUNT   <= edge_cnt;
        FREQ_OK <= in_range;
      end

      if ((state == GATE) && lock_fall) ERR <= 1'b1;
      else if (start_ok)                ERR <= 1'b0;

      if (lock_fall && (LOCK_LOSS_CNT != 8'hFF)) LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_clk_mon.sv
// Directed self-checking bench for clk_mon: nominal window, saturation, lock-loss abort,
// lock-loss counter saturation, mid-window reset, ignored re-START and (optionally) continuous mode.
`timescale 1ns/1ps
module tb_clk_mon;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       start_a, start_b;
  logic       cont_a, cont_b;
  logic [7:0] ph;
  logic       mon_a, mon_b;

  logic        busy_a, valid_a, freq_ok_a, err_a;
  logic [15:0] count_a;
  logic [7:0]  llc_a;
  logic        busy_b, valid_b, freq_ok_b, err_b;
  logic [3:0]  count_b;
  logic [7:0]  llc_b;

  int passed = 0;
  int total  = 0;

  assign mon_a = ph[3];   // period 16 cycles
  assign mon_b = ph[1];   // period 4 cycles

  clk_mon #(.GATE_LEN(1600), .CNT_WIDTH(16), .MIN_CNT(95), .MAX_CNT(105)) dut_a (
    .BUS_CLK(clk), .BUS_RST(rst), .MON_IN(mon_a), .LOCKED_IN(locked), .START(start_a),
`ifdef CLK_MON_CONT_EN
    .CONT(cont_a),
`endif
    .BUSY(busy_a), .COUNT(count_a), .VALID(valid_a), .FREQ_OK(freq_ok_a),
    .ERR(err_a), .LOCK_LOSS_CNT(llc_a)
  );

  clk_mon #(.GATE_LEN(200), .CNT_WIDTH(4)) dut_b (
    .BUS_CLK(clk), .BUS_RST(rst), .MON_IN(mon_b), .LOCKED_IN(locked), .START(start_b),
`ifdef CLK_MON_CONT_EN
    .CONT(cont_b),
`endif
    .BUSY(busy_b), .COUNT(count_b), .VALID(valid_b), .FREQ_OK(freq_ok_b),
    .ERR(err_b), .LOCK_LOSS_CNT(llc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ph = '0;
    forever begin
      @(negedge clk);
      ph = ph + 8'd1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Pulse START on one DUT and return the number of negedges until VALID is seen (1 = first negedge).
  task automatic run_window(input bit sel, input int limit, output int lat);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 1;
    check(sel ? "busy_b_gate" : "busy_a_gate", sel ? busy_b : busy_a, 1);
    while (!(sel ? valid_b : valid_a) && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int k;
    int vcount;
    logic [15:0] saved;

    rst = 1'b1; locked = 1'b1; start_a = 1'b0; start_b = 1'b0;
    cont_a = 1'b0; cont_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",    busy_a,    0);
    check("rst_count",   count_a,   0);
    check("rst_valid",   valid_a,   0);
    check("rst_freq_ok", freq_ok_a, 0);
    check("rst_err",     err_a,     0);
    check("rst_llc",     llc_a,     0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", busy_a, 0);

    // Nominal window: 1600 cycles at period 16 -> 100 edges, VALID 1601 edges after START.
    run_window(0, 2000, lat);
    check("lat_a", lat - 1, 1601);
    check("count_a_100", (count_a >= 16'd99) && (count_a <= 16'd101), 1);
    check("freq_ok_a", freq_ok_a, 1);
    @(negedge clk);
    check("valid_a_one_cycle", valid_a, 0);
    saved = count_a;
    repeat (50) @(negedge clk);
    check("count_a_hold", count_a, saved);

    // Saturation: 200 cycles at period 4 -> 50 edges, clipped to 15 in 4 bits.
    run_window(1, 400, lat);
    check("lat_b", lat - 1, 201);
    check("count_b_sat", count_b, 15);
    check("freq_ok_b", freq_ok_b, 1);

    // Lock loss at cycle 500 of the window aborts without VALID.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    vcount = 0;
    for (k = 1; k < 1800; k++) begin
      if (k == 500) locked = 1'b0;
      if (valid_a) vcount++;
      @(negedge clk);
    end
    check("abort_no_valid", vcount, 0);
    check("abort_err",      err_a,  1);
    check("abort_llc",      llc_a,  1);
    check("abort_busy",     busy_a, 0);
    check("abort_count",    count_a, saved);
    locked = 1'b1;
    repeat (5) @(negedge clk);
    run_window(0, 2000, lat);
    check("restart_err_clear", err_a, 0);
    check("restart_lat", lat - 1, 1601);

    // 300 further lock drops saturate the counter.
    repeat (300) begin
      locked = 1'b0;
      repeat (2) @(negedge clk);
      locked = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("llc_a_sat", llc_a, 255);
    check("llc_b_sat", llc_b, 255);
    check("idle_lock_no_err_b", err_b, 0);

    // Asynchronous reset in the middle of a window.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", busy_a, 1);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy",    busy_a,    0);
    check("mrst_count",   count_a,   0);
    check("mrst_valid",   valid_a,   0);
    check("mrst_freq_ok", freq_ok_a, 0);
    check("mrst_err",     err_a,     0);
    check("mrst_llc",     llc_a,     0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", busy_a, 0);

    // START repeated in GATE and in DONE is ignored: exactly one VALID.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    vcount = 0;
    for (k = 1; k < 3400; k++) begin
      if (valid_a) vcount++;
      start_a = (k == 10) || (k == 800) || (k == 1601);
      @(negedge clk);
    end
    start_a = 1'b0;
    check("single_valid", vcount, 1);
    check("single_count", (count_a >= 16'd99) && (count_a <= 16'd101), 1);

`ifdef CLK_MON_CONT_EN
    // Continuous mode: strobes every GATE_LEN+1 cycles, stop after the current window on CONT=0.
    cont_a = 1'b1;
    run_window(0, 2000, lat);
    check("cont_first_lat", lat - 1, 1601);
    repeat (2) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!valid_a && k < 2000);
      check("cont_interval", k, 1601);
    end
    cont_a = 1'b0;
    vcount = 0;
    for (k = 0; k < 3400; k++) begin
      @(negedge clk);
      if (valid_a) vcount++;
    end
    check("cont_stop", vcount, 1);
    check("cont_idle", busy_a, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
